// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM frame arbiter: FSM states, channel ids and the
// helper that sizes the in-burst beat counter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {ST_INIT, ST_ARB, ST_CMD, ST_XFER} arb_state_e;

    typedef enum logic {CH_WR, CH_RD} arb_chan_e;

    // Bits needed to count beats 0 .. burst_len-1.
    function automatic int unsigned burst_cnt_w(input int unsigned burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/sdram_frame_chan.sv
// One frame-buffer channel: frame offset, bank, active flag, deferred
// frame-start handling and burst address generation.
module sdram_frame_chan #(
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned BANK_STRIDE = 524288,
    parameter logic        RESET_BANK  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              in_burst,
    input  logic              burst_done,
    input  logic              next_bank,
    output logic              active,
    output logic              bank,
    output logic              frame_done,
    output logic [ADDR_W-1:0] addr
);

    localparam int unsigned OFF_W = $clog2(FRAME_WORDS + 1);

    logic [OFF_W-1:0] off_q, off_d;
    logic             bank_q, bank_d;
    logic             active_q, active_d;
    logic             pend_q, pend_d;
    logic             start_req;

    always_comb begin
        off_d      = off_q;
        bank_d     = bank_q;
        active_d   = active_q;
        pend_d     = pend_q;
        frame_done = 1'b0;
        start_req  = frame_start | pend_q;

        if (burst_done) begin
            off_d = off_q + OFF_W'(BURST_LEN);
            if (off_d >= OFF_W'(FRAME_WORDS)) begin
                active_d   = 1'b0;
                frame_done = 1'b1;
            end
        end

        // A start during our own burst waits for it; at completion it overrides the offset.
        if (in_burst && !burst_done) begin
            pend_d = start_req;
        end else begin
            pend_d = 1'b0;
            if (start_req) begin
                off_d    = '0;
                bank_d   = next_bank;
                active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q    <= '0;
            bank_q   <= RESET_BANK;
            active_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            off_q    <= off_d;
            bank_q   <= bank_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

    assign active = active_q;
    assign bank   = bank_q;
    assign addr   = (bank_q ? ADDR_W'(BANK_STRIDE) : '0) + ADDR_W'(off_q);

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Shares the SDRAM command port between the camera write and video read channels.
// Define ARB_STATS_EN to add burst/stall counters and the write-overrun flag.
module sdram_frame_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned FIFO_AW     = 10,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned BANK_STRIDE = 524288,
    parameter int unsigned RD_URGENT   = 768
) (
    input  logic              memory_clk,
    input  logic              rst,
    input  logic              sdrc_init_done,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic [FIFO_AW:0]  wr_fifo_level,
    input  logic [FIFO_AW:0]  rd_fifo_space,
    input  logic              cmd_ready,
    output logic              cmd_en,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              data_beat,
    output logic              wr_bank,
    output logic              rd_bank,
`ifdef ARB_STATS_EN
    output logic [15:0]       wr_bursts,
    output logic [15:0]       rd_bursts,
    output logic [15:0]       stall_cycles,
    output logic              wr_overrun,
`endif
    output logic              busy
);

    localparam int unsigned LVL_W  = FIFO_AW + 1;
    localparam int unsigned BEAT_W = burst_cnt_w(BURST_LEN);
    localparam logic [FIFO_AW:0]  BURST_LVL  = LVL_W'(BURST_LEN);
    localparam logic [FIFO_AW:0]  URGENT_LVL = LVL_W'(RD_URGENT);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);

    arb_state_e          state_q, state_d;
    arb_chan_e           last_grant_q, last_grant_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                done_bank_q, done_bank_d;

    logic                wr_active, rd_active;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic                wr_frame_done;
    logic                unused_rd_frame_done;
    logic                wr_elig, rd_elig, rd_urgent;
    logic                grant_wr, grant_rd;
    logic                beat_last, wr_burst_done, rd_burst_done;
    logic                wr_in_burst, rd_in_burst;

    assign busy        = (state_q == ST_CMD) || (state_q == ST_XFER);
    assign cmd_en      = (state_q == ST_CMD);
    assign cmd_wr      = cmd_wr_q;
    assign cmd_addr    = cmd_addr_q;
    assign wr_in_burst = busy && cmd_wr_q;
    assign rd_in_burst = busy && !cmd_wr_q;

    always_comb begin
        wr_elig   = wr_active && (wr_fifo_level >= BURST_LVL);
        rd_elig   = rd_active && (rd_fifo_space >= BURST_LVL);
        rd_urgent = rd_fifo_space >= URGENT_LVL;
        grant_rd  = rd_elig && (!wr_elig || rd_urgent || (last_grant_q == CH_WR));
        grant_wr  = wr_elig && !grant_rd;

        beat_last = (state_q == ST_XFER) && sdrc_init_done && data_beat && (beat_q == BEAT_LAST);
        wr_burst_done = beat_last && cmd_wr_q;
        rd_burst_done = beat_last && !cmd_wr_q;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_wr_d     = cmd_wr_q;
        cmd_addr_d   = cmd_addr_q;
        beat_d       = beat_q;
        done_bank_d  = wr_frame_done ? wr_bank : done_bank_q;

        if (!sdrc_init_done) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_ARB;
                ST_ARB: begin
                    if (grant_wr || grant_rd) begin
                        state_d      = ST_CMD;
                        cmd_wr_d     = grant_wr;
                        cmd_addr_d   = grant_wr ? wr_addr : rd_addr;
                        last_grant_d = grant_wr ? CH_WR : CH_RD;
                    end
                end
                ST_CMD: begin
                    if (cmd_ready) begin
                        state_d = ST_XFER;
                        beat_d  = '0;
                    end
                end
                ST_XFER: begin
                    if (data_beat) begin
                        if (beat_q == BEAT_LAST) begin
                            state_d = ST_ARB;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge memory_clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            last_grant_q <= CH_RD;
            cmd_wr_q     <= 1'b0;
            cmd_addr_q   <= '0;
            beat_q       <= '0;
            done_bank_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_wr_q     <= cmd_wr_d;
            cmd_addr_q   <= cmd_addr_d;
            beat_q       <= beat_d;
            done_bank_q  <= done_bank_d;
        end
    end

    sdram_frame_chan #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .BANK_STRIDE (BANK_STRIDE),
        .RESET_BANK  (1'b0)
    ) u_wr_chan (
        .clk         (memory_clk),
        .rst         (rst),
        .frame_start (wr_frame_start),
        .in_burst    (wr_in_burst),
        .burst_done  (wr_burst_done),
        .next_bank   (~wr_bank),
        .active      (wr_active),
        .bank        (wr_bank),
        .frame_done  (wr_frame_done),
        .addr        (wr_addr)
    );

    // Reads always replay the most recently completed camera frame.
    sdram_frame_chan #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .BANK_STRIDE (BANK_STRIDE),
        .RESET_BANK  (1'b1)
    ) u_rd_chan (
        .clk         (memory_clk),
        .rst         (rst),
        .frame_start (rd_frame_start),
        .in_burst    (rd_in_burst),
        .burst_done  (rd_burst_done),
        .next_bank   (done_bank_q),
        .active      (rd_active),
        .bank        (rd_bank),
        .frame_done  (unused_rd_frame_done),
        .addr        (rd_addr)
    );

`ifdef ARB_STATS_EN
    logic [15:0] wr_bursts_q, wr_bursts_d;
    logic [15:0] rd_bursts_q, rd_bursts_d;
    logic [15:0] stall_q, stall_d;
    logic        wr_overrun_q, wr_overrun_d;

    always_comb begin
        wr_bursts_d  = wr_bursts_q;
        rd_bursts_d  = rd_bursts_q;
        stall_d      = stall_q;
        wr_overrun_d = wr_overrun_q;
        if (wr_burst_done && (wr_bursts_q != 16'hFFFF)) wr_bursts_d = wr_bursts_q + 16'd1;
        if (rd_burst_done && (rd_bursts_q != 16'hFFFF)) rd_bursts_d = rd_bursts_q + 16'd1;
        if ((state_q == ST_CMD) && !cmd_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        // A new camera frame before the previous one finished writing.
        if (wr_frame_start && wr_active) wr_overrun_d = 1'b1;
    end

    always_ff @(posedge memory_clk) begin
        if (rst) begin
            wr_bursts_q  <= '0;
            rd_bursts_q  <= '0;
            stall_q      <= '0;
            wr_overrun_q <= 1'b0;
        end else begin
            wr_bursts_q  <= wr_bursts_d;
            rd_bursts_q  <= rd_bursts_d;
            stall_q      <= stall_d;
            wr_overrun_q <= wr_overrun_d;
        end
    end

    assign wr_bursts    = wr_bursts_q;
    assign rd_bursts    = rd_bursts_q;
    assign stall_cycles = stall_q;
    assign wr_overrun   = wr_overrun_q;
`endif

endmodule
